// File: rtl/mnacidpro_pkg.sv
// Shared constants, state encoding and pump phase table for the mnacidpro valve sequencer.
package mnacidpro_pkg;

  localparam int unsigned NUM_VALVES     = 13;
  localparam int unsigned NUM_PUMP       = 3;
  localparam int unsigned NUM_PHASES     = 6;
  localparam int unsigned PUMP_VALVE_IDX = 6;

  localparam logic [NUM_VALVES-1:0] ALL_CLOSED_V = 13'h1FFF;
  localparam logic [NUM_PUMP-1:0]   ALL_CLOSED_P = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StOpen,
    StRun,
    StClose
  } seq_state_e;

  // Closed pattern per phase, packed as {p3,p2,p1}; 1 = pressurised = closed.
  function automatic logic [NUM_PUMP-1:0] pump_pattern(input logic [2:0] phase);
    logic [NUM_PUMP-1:0] pat;
    case (phase)
      3'd0:    pat = 3'b001;
      3'd1:    pat = 3'b011;
      3'd2:    pat = 3'b010;
      3'd3:    pat = 3'b110;
      3'd4:    pat = 3'b100;
      3'd5:    pat = 3'b101;
      default: pat = ALL_CLOSED_P;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/mnacidpro_pump_phase_gen.sv
// Peristaltic pump phase walker: advances one phase per step tick, flags each full cycle.
module mnacidpro_pump_phase_gen
  import mnacidpro_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                tick_i,
  output logic [NUM_PUMP-1:0] pump_ctl_o,
  output logic                cycle_done_o
);

  logic [2:0]          phase_q, phase_d;
  logic [NUM_PUMP-1:0] pat_q, pat_d;

  assign cycle_done_o = tick_i && (phase_q == 3'(NUM_PHASES - 1));

  always_comb begin
    phase_d = phase_q;
    if (!en_i) begin
      phase_d = 3'd0;
    end else if (tick_i) begin
      phase_d = (phase_q == 3'(NUM_PHASES - 1)) ? 3'd0 : phase_q + 3'd1;
    end
    // en_i reflects the next state, so the pattern lands on the first RUN cycle.
    pat_d = en_i ? pump_pattern(phase_d) : ALL_CLOSED_P;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= 3'd0;
      pat_q   <= ALL_CLOSED_P;
    end else begin
      phase_q <= phase_d;
      pat_q   <= pat_d;
    end
  end

  assign pump_ctl_o = pat_q;

endmodule

// File: rtl/mnacidpro_valve_sequencer.sv
// Command-driven valve/pump sequencer: OPEN settle, optional pump or hold RUN, CLOSE settle.
module mnacidpro_valve_sequencer
  import mnacidpro_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned STEP_CYCLES   = 1000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [NUM_VALVES-1:0] cmd_open_mask_i,
  input  logic                  cmd_pump_en_i,
  input  logic [CNT_W-1:0]      cmd_count_i,
  input  logic                  abort_i,
  output logic [NUM_VALVES-1:0] valve_ctl_o,
  output logic [NUM_PUMP-1:0]   pump_ctl_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o
);

  localparam int unsigned UnitW = CNT_W + 3;

  seq_state_e            state_q, state_d;
  logic [31:0]           tmr_q, tmr_d;
  logic [UnitW-1:0]      units_q, units_d;
  logic [NUM_VALVES-1:0] mask_q, mask_d;
  logic                  pump_en_q, pump_en_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [NUM_VALVES-1:0] valve_q, valve_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;

  logic                  accept, step_tick, unit_evt, last_unit, settled, gen_en, cycle_done;
  logic [NUM_VALVES-1:0] open_v;

  assign step_tick = (state_q == StRun) && (tmr_q == STEP_CYCLES - 1);
  assign gen_en    = (state_d == StRun) && pump_en_q;

  mnacidpro_pump_phase_gen u_phase_gen (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (gen_en),
    .tick_i       (step_tick),
    .pump_ctl_o   (pump_ctl_o),
    .cycle_done_o (cycle_done)
  );

  always_comb begin
    accept    = (state_q == StIdle) && cmd_valid_i && ready_q && !abort_i;
    settled   = (tmr_q == SETTLE_CYCLES - 1);
    // A unit is one full pump cycle when pumping, otherwise one hold step.
    unit_evt  = pump_en_q ? cycle_done : step_tick;
    last_unit = unit_evt && (units_q + UnitW'(1) == UnitW'(count_q));

    state_d   = state_q;
    tmr_d     = tmr_q + 32'd1;
    units_d   = units_q;
    mask_d    = mask_q;
    pump_en_d = pump_en_q;
    count_d   = count_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmr_d   = '0;
        units_d = '0;
        if (accept) begin
          mask_d    = cmd_open_mask_i;
          pump_en_d = cmd_pump_en_i;
          count_d   = cmd_count_i;
          state_d   = StOpen;
        end
      end
      StOpen: begin
        if (settled) begin
          tmr_d   = '0;
          state_d = (count_q == '0) ? StClose : StRun;
        end
      end
      StRun: begin
        if (step_tick) tmr_d = '0;
        if (unit_evt && (units_q != '1)) units_d = units_q + UnitW'(1);
        if (last_unit) begin
          tmr_d   = '0;
          state_d = StClose;
        end
      end
      StClose: begin
        if (settled) begin
          tmr_d   = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort skips the CLOSE settle and never produces done.
    if (abort_i && (state_q != StIdle)) begin
      state_d   = StIdle;
      tmr_d     = '0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end

    open_v = ~mask_d;
    if (pump_en_d) open_v[PUMP_VALVE_IDX] = 1'b0;
    valve_d = ((state_d == StOpen) || (state_d == StRun)) ? open_v : ALL_CLOSED_V;
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle) && !done_d && !aborted_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      tmr_q     <= '0;
      units_q   <= '0;
      mask_q    <= '0;
      pump_en_q <= 1'b0;
      count_q   <= '0;
      valve_q   <= ALL_CLOSED_V;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      units_q   <= units_d;
      mask_q    <= mask_d;
      pump_en_q <= pump_en_d;
      count_q   <= count_d;
      valve_q   <= valve_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign valve_ctl_o = valve_q;
  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_mnacidpro_valve_sequencer.sv
// Scoreboard bench: each command pushes its expected per-cycle outputs, sampled on the falling edge.
module tb_mnacidpro_valve_sequencer;

  localparam int unsigned S = 4;
  localparam int unsigned P = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [12:0] cmd_open_mask = '0;
  logic        cmd_pump_en = 1'b0;
  logic [15:0] cmd_count = '0;
  logic        abort = 1'b0;
  logic [12:0] valve_ctl;
  logic [2:0]  pump_ctl;
  logic        busy, done, aborted;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [12:0] v;
    logic [2:0]  p;
    logic        d;
    logic        a;
    logic        b;
    logic        r;
  } exp_t;

  exp_t sb_q[$];

  mnacidpro_valve_sequencer #(
    .SETTLE_CYCLES (S),
    .STEP_CYCLES   (P),
    .CNT_W         (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_open_mask_i (cmd_open_mask),
    .cmd_pump_en_i   (cmd_pump_en),
    .cmd_count_i     (cmd_count),
    .abort_i         (abort),
    .valve_ctl_o     (valve_ctl),
    .pump_ctl_o      (pump_ctl),
    .busy_o          (busy),
    .done_o          (done),
    .aborted_o       (aborted)
  );

  always #5 clk = ~clk;

  // {p3,p2,p1} closed patterns for phases 0..5.
  function automatic logic [2:0] pat(input int ph);
    case (ph)
      0:       return 3'b001;
      1:       return 3'b011;
      2:       return 3'b010;
      3:       return 3'b110;
      4:       return 3'b100;
      default: return 3'b101;
    endcase
  endfunction

  function automatic exp_t mk(input logic [12:0] v, input logic [2:0] p, input logic d,
                              input logic a, input logic b, input logic r);
    exp_t e;
    e.v = v; e.p = p; e.d = d; e.a = a; e.b = b; e.r = r;
    return e;
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(mk(13'h1FFF, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  // Expected outputs for cycles T+1 onwards after an accept at T, ending with ready back.
  task automatic push_cmd(input logic [12:0] mask, input logic pump, input int count);
    logic [12:0] ov;
    ov = ~mask;
    if (pump) ov[6] = 1'b0;
    for (int i = 0; i < int'(S); i++) sb_q.push_back(mk(ov, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0));
    if (pump) begin
      for (int c = 0; c < count; c++)
        for (int ph = 0; ph < 6; ph++)
          for (int k = 0; k < int'(P); k++)
            sb_q.push_back(mk(ov, pat(ph), 1'b0, 1'b0, 1'b1, 1'b0));
    end else begin
      for (int i = 0; i < count * int'(P); i++)
        sb_q.push_back(mk(ov, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    for (int i = 0; i < int'(S); i++)
      sb_q.push_back(mk(13'h1FFF, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0));
    sb_q.push_back(mk(13'h1FFF, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0));
    sb_q.push_back(mk(13'h1FFF, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic drain(input string name);
    exp_t e, o;
    int   idx = 0;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = {valve_ctl, pump_ctl, done, aborted, busy, cmd_ready};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle+%0d: got v=%h p=%b done=%b abrt=%b busy=%b rdy=%b, exp v=%h p=%b done=%b abrt=%b busy=%b rdy=%b",
                 name, idx + 1, o.v, o.p, o.d, o.a, o.b, o.r, e.v, e.p, e.d, e.a, e.b, e.r);
      end
      idx++;
    end
  endtask

  // Drives one command at a negedge; the following posedge is the accept edge T.
  task automatic start_cmd(input logic [12:0] mask, input logic pump, input int count,
                           input string name);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready-before-accept: got %b, exp 1", name, cmd_ready);
    end
    cmd_valid     = 1'b1;
    cmd_open_mask = mask;
    cmd_pump_en   = pump;
    cmd_count     = 16'(count);
    @(posedge clk);
    #1;
    cmd_valid     = 1'b0;
    // Changing fields while busy must have no effect.
    cmd_open_mask = 13'h0AAA;
    cmd_pump_en   = ~pump;
    cmd_count     = 16'd7;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (valve_ctl !== 13'h1FFF) begin
      errors++; $display("FAIL reset valve_ctl: got %h, exp 1fff", valve_ctl);
    end
    checks++;
    if (pump_ctl !== 3'b111) begin
      errors++; $display("FAIL reset pump_ctl: got %b, exp 111", pump_ctl);
    end
    checks++;
    if ({cmd_ready, busy, done, aborted} !== 4'b1000) begin
      errors++;
      $display("FAIL reset flags rdy/busy/done/abrt: got %b, exp 1000",
               {cmd_ready, busy, done, aborted});
    end
    rst = 1'b0;
    push_idle(2);
    drain("reset_idle");
  endtask

  task automatic test_route;
    start_cmd(13'h0801, 1'b0, 3, "route");
    push_cmd(13'h0801, 1'b0, 3);
    drain("route");
  endtask

  task automatic test_pump;
    start_cmd(13'h0000, 1'b1, 2, "pump");
    push_cmd(13'h0000, 1'b1, 2);
    drain("pump");
  endtask

  task automatic test_count_zero;
    start_cmd(13'h1000, 1'b0, 0, "count0");
    push_cmd(13'h1000, 1'b0, 0);
    drain("count0");
  endtask

  task automatic test_abort;
    start_cmd(13'h0010, 1'b1, 3, "abort");
    push_cmd(13'h0010, 1'b1, 3);
    while (sb_q.size() > int'(S) + 3) void'(sb_q.pop_back());
    drain("abort_pre");
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    sb_q.push_back(mk(13'h1FFF, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0));
    push_idle(12);
    drain("abort_post");
  endtask

  task automatic test_back_to_back;
    start_cmd(13'h0003, 1'b0, 1, "b2b");
    cmd_valid = 1'b1;
    push_cmd(13'h0003, 1'b0, 1);
    void'(sb_q.pop_back());
    drain("b2b_busy");
    cmd_valid = 1'b0;
    push_idle(8);
    drain("b2b_after");
    @(negedge clk);
    cmd_valid = 1'b1;
    abort     = 1'b1;
    push_idle(4);
    drain("valid_with_abort");
    cmd_valid = 1'b0;
    abort     = 1'b0;
    push_idle(2);
    drain("valid_with_abort_after");
  endtask

  task automatic test_reset_mid;
    start_cmd(13'h0100, 1'b1, 2, "rst_mid");
    push_cmd(13'h0100, 1'b1, 2);
    while (sb_q.size() > int'(S) + 1) void'(sb_q.pop_back());
    drain("rst_mid_pre");
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({valve_ctl, pump_ctl} !== {13'h1FFF, 3'b111}) begin
      errors++;
      $display("FAIL rst_mid closed: got v=%h p=%b, exp v=1fff p=111", valve_ctl, pump_ctl);
    end
    checks++;
    if ({busy, done, aborted} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid flags busy/done/abrt: got %b, exp 000", {busy, done, aborted});
    end
    @(negedge clk);
    rst = 1'b0;
    push_idle(6);
    drain("rst_mid_after");
  endtask

  initial begin
    test_reset();
    test_route();
    test_pump();
    test_count_zero();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
